// File: rtl/mem_bus_pkg.sv
// Shared widths, FSM state encoding and request payload for the memory bus master.
package mem_bus_pkg;

  localparam int unsigned ADDR_W            = 12;
  localparam int unsigned DATA_W            = 8;
  localparam int unsigned CNT_W             = 4;
  localparam int unsigned ACCESS_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Request latched at acceptance and held for the whole bus cycle
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_bus_master_if.sv
// Request/response handshake between a client (master side) and the bus master (slave side).
interface mem_bus_master_if;
  import mem_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_bus_master.sv
// Asynchronous SRAM-style bus master: SETUP / ACCESS / HOLD sequencing with registered strobes.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF  // strobe low time, 1..15
) (
  input  logic              clk,
  input  logic              notReset,
  mem_bus_master_if.slave   bus,
  output logic [ADDR_W-1:0] address,
  output logic              notChipEnable,
  output logic              notOutputEnable,
  output logic              notWriteEnable,
  inout  wire  [DATA_W-1:0] io
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  state_t             r_state;
  req_t               r_req;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic               r_io_oe;
  logic               r_ready;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rdata;

  // Sequencer: every bus-facing output is a flop so strobes never glitch
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_io_oe     <= 1'b0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_ready) begin
            r_state <= SETUP;
            r_ready <= 1'b0;
            r_req   <= '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
            r_addr  <= bus.req_addr;
            r_ce_n  <= 1'b0;
            r_io_oe <= bus.req_write;
          end else begin
            r_ready <= 1'b1;
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          r_cnt   <= CNT_LOAD;
          r_oe_n  <= r_req.write;
          r_we_n  <= !r_req.write;
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_state     <= HOLD;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_rsp_valid <= 1'b1;
            if (!r_req.write) begin
              r_rdata <= io;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          r_state     <= IDLE;
          r_ce_n      <= 1'b1;
          r_io_oe     <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_ready     <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Data bus is only driven from SETUP through HOLD of a write
  assign io = r_io_oe ? r_req.wdata : {DATA_W{1'bz}};

  assign address         = r_addr;
  assign notChipEnable   = r_ce_n;
  assign notOutputEnable = r_oe_n;
  assign notWriteEnable  = r_we_n;
  assign bus.req_ready   = r_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rdata;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two instances (ACCESS_CYCLES=2 and 1) against a memory device and a transaction-level model.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  localparam int NDUT = 2;
  localparam int AC0  = 2;
  localparam int AC1  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n        [NDUT];
  logic        tb_valid     [NDUT];
  logic        tb_write     [NDUT];
  logic [11:0] tb_req_addr  [NDUT];
  logic [7:0]  tb_wdata     [NDUT];
  logic        tb_ready     [NDUT];
  logic        tb_rsp_valid [NDUT];
  logic [7:0]  tb_rdata     [NDUT];
  logic [11:0] tb_address   [NDUT];
  logic        tb_ce_n      [NDUT];
  logic        tb_oe_n      [NDUT];
  logic        tb_we_n      [NDUT];
  logic [7:0]  tb_io        [NDUT];

  logic [7:0] mem     [NDUT][4096];  // memory device contents
  logic [7:0] ref_mem [NDUT][4096];  // model view of memory
  logic [7:0] exp_rdata [NDUT];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_bus_master_if u_if ();
    wire  [7:0]  io;
    logic [11:0] address;
    logic        ce_n, oe_n, we_n;

    assign u_if.req_valid = tb_valid[g];
    assign u_if.req_write = tb_write[g];
    assign u_if.req_addr  = tb_req_addr[g];
    assign u_if.req_wdata = tb_wdata[g];
    assign tb_ready[g]     = u_if.req_ready;
    assign tb_rsp_valid[g] = u_if.rsp_valid;
    assign tb_rdata[g]     = u_if.rsp_rdata;
    assign tb_address[g]   = address;
    assign tb_ce_n[g]      = ce_n;
    assign tb_oe_n[g]      = oe_n;
    assign tb_we_n[g]      = we_n;
    assign tb_io[g]        = io;

    // Memory device drives the bus only while selected and output-enabled
    assign io = (!ce_n && !oe_n) ? mem[g][address] : 8'bz;
    for (genvar b = 0; b < 8; b++) begin : g_pu
      pullup (io[b]);
    end

    mem_bus_master #(.ACCESS_CYCLES((g == 0) ? AC0 : AC1)) u_dut (
      .clk             (clk),
      .notReset        (rst_n[g]),
      .bus             (u_if),
      .address         (address),
      .notChipEnable   (ce_n),
      .notOutputEnable (oe_n),
      .notWriteEnable  (we_n),
      .io              (io)
    );
  end

  // Memory device write port
  always @(posedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (!tb_ce_n[g] && !tb_we_n[g]) mem[g][tb_address[g]] <= tb_io[g];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Read and write strobes must never overlap
  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (rst_n[g] === 1'b1) check_eq("oe_we_excl", 32'(!tb_oe_n[g] && !tb_we_n[g]), 32'd0);
    end
  end

  task automatic reset_seq(input int g);
    @(negedge clk);
    rst_n[g] = 1'b0;
    #1;
    check_eq("rst_ce_n",  32'(tb_ce_n[g]), 32'd1);
    check_eq("rst_oe_n",  32'(tb_oe_n[g]), 32'd1);
    check_eq("rst_we_n",  32'(tb_we_n[g]), 32'd1);
    check_eq("rst_io_z",  32'(tb_io[g]), 32'hFF);
    check_eq("rst_addr",  32'(tb_address[g]), 32'd0);
    check_eq("rst_rsp_v", 32'(tb_rsp_valid[g]), 32'd0);
    check_eq("rst_rdata", 32'(tb_rdata[g]), 32'd0);
    check_eq("rst_ready", 32'(tb_ready[g]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n[g] = 1'b1;
    #1;
    check_eq("ready_before_edge", 32'(tb_ready[g]), 32'd0);
    @(negedge clk);
    check_eq("ready_after_edge", 32'(tb_ready[g]), 32'd1);
    exp_rdata[g] = 8'h00;
  endtask

  // One transaction, checked cycle by cycle from the timing rules; returns at the IDLE cycle after HOLD
  task automatic run_txn(input int g, input bit wr, input logic [11:0] a, input logic [7:0] d,
                         input bit keep_valid, output int waited, output int setup_cyc);
    int         n;
    logic [7:0] rd_exp;
    bit         strobe;
    n = (g == 0) ? AC0 : AC1;
    tb_valid[g] = 1'b1; tb_write[g] = wr; tb_req_addr[g] = a; tb_wdata[g] = d;
    waited = 0;
    setup_cyc = -1;
    while (tb_ready[g] !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      check_eq("accept_timeout", 32'(waited), 32'd0);
      tb_valid[g] = 1'b0;
      return;
    end
    @(negedge clk);
    setup_cyc = cyc;
    if (!keep_valid) tb_valid[g] = 1'b0;
    rd_exp = ref_mem[g][a];
    for (int k = 1; k <= n + 2; k++) begin
      strobe = (k >= 2) && (k <= n + 1);
      check_eq("busy_ready", 32'(tb_ready[g]), 32'd0);
      check_eq("ce_n",       32'(tb_ce_n[g]), 32'd0);
      check_eq("address",    32'(tb_address[g]), 32'(a));
      check_eq("oe_n",       32'(tb_oe_n[g]), 32'((!wr && strobe) ? 1'b0 : 1'b1));
      check_eq("we_n",       32'(tb_we_n[g]), 32'((wr && strobe) ? 1'b0 : 1'b1));
      check_eq("rsp_valid",  32'(tb_rsp_valid[g]), 32'(k == n + 2));
      if (wr) check_eq("io_wdata", 32'(tb_io[g]), 32'(d));
      else    check_eq("io_read",  32'(tb_io[g]), 32'(strobe ? rd_exp : 8'hFF));
      @(negedge clk);
    end
    if (wr) ref_mem[g][a] = d;
    else    exp_rdata[g] = rd_exp;
    check_eq("idle_ready",  32'(tb_ready[g]), 32'd1);
    check_eq("idle_ce_n",   32'(tb_ce_n[g]), 32'd1);
    check_eq("idle_oe_n",   32'(tb_oe_n[g]), 32'd1);
    check_eq("idle_we_n",   32'(tb_we_n[g]), 32'd1);
    check_eq("idle_rsp_v",  32'(tb_rsp_valid[g]), 32'd0);
    check_eq("idle_addr",   32'(tb_address[g]), 32'(a));
    check_eq("idle_io_z",   32'(tb_io[g]), 32'hFF);
    check_eq("rsp_rdata",   32'(tb_rdata[g]), 32'(exp_rdata[g]));
  endtask

  initial begin
    int w0, w1, s0, s1;
    int         g;
    bit         wr;
    logic [11:0] a;
    logic [7:0]  d;

    for (int i = 0; i < NDUT; i++) begin
      rst_n[i] = 1'b0; tb_valid[i] = 1'b0; tb_write[i] = 1'b0;
      tb_req_addr[i] = '0; tb_wdata[i] = '0; exp_rdata[i] = '0;
      for (int j = 0; j < 4096; j++) begin
        mem[i][j]     = 8'($urandom);
        ref_mem[i][j] = mem[i][j];
      end
    end
    mem[0][12'h005] = 8'hA3; ref_mem[0][12'h005] = 8'hA3;
    mem[1][12'h003] = 8'h3C; ref_mem[1][12'h003] = 8'h3C;

    reset_seq(0);
    reset_seq(1);

    // Directed read and write on the two-cycle instance
    run_txn(0, 1'b0, 12'h005, 8'h00, 1'b0, w0, s0);
    check_eq("rom_read_a3", 32'(tb_rdata[0]), 32'hA3);
    run_txn(0, 1'b1, 12'h7FF, 8'h5C, 1'b0, w0, s0);
    check_eq("write_keeps_rdata", 32'(tb_rdata[0]), 32'hA3);

    // Back-to-back reads with req_valid held high
    @(negedge clk);
    run_txn(0, 1'b0, 12'h010, 8'h00, 1'b1, w0, s0);
    run_txn(0, 1'b0, 12'h011, 8'h00, 1'b0, w1, s1);
    check_eq("b2b_accept_wait", 32'(w1), 32'd0);
    check_eq("b2b_setup_gap", 32'(s1 - s0), 32'(AC0 + 3));

    // Reset in the middle of a write's ACCESS phase
    @(negedge clk);
    tb_valid[0] = 1'b1; tb_write[0] = 1'b1; tb_req_addr[0] = 12'h100; tb_wdata[0] = 8'h77;
    w0 = 0;
    while (tb_ready[0] !== 1'b1 && w0 < 50) begin @(negedge clk); w0++; end
    check_eq("abort_accept", 32'(tb_ready[0]), 32'd1);
    @(negedge clk);
    tb_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("abort_we_active", 32'(tb_we_n[0]), 32'd0);
    #2 rst_n[0] = 1'b0;
    #1;
    check_eq("abort_we_n", 32'(tb_we_n[0]), 32'd1);
    check_eq("abort_ce_n", 32'(tb_ce_n[0]), 32'd1);
    check_eq("abort_oe_n", 32'(tb_oe_n[0]), 32'd1);
    check_eq("abort_io_z", 32'(tb_io[0]), 32'hFF);
    check_eq("abort_rsp_v", 32'(tb_rsp_valid[0]), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_no_rsp", 32'(tb_rsp_valid[0]), 32'd0);
    end
    rst_n[0] = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", 32'(tb_ready[0]), 32'd1);
    exp_rdata[0] = 8'h00;
    run_txn(0, 1'b0, 12'h020, 8'h00, 1'b0, w0, s0);

    // Single-cycle access instance
    run_txn(1, 1'b0, 12'h003, 8'h00, 1'b0, w0, s0);
    check_eq("ac1_read_3c", 32'(tb_rdata[1]), 32'h3C);

    // Randomized traffic on both instances
    for (int i = 0; i < 60; i++) begin
      g  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = (i % 8 == 7) ? 12'h100 ^ 12'h001 : 12'($urandom);
      if (a == 12'h100) a = 12'h101;
      d  = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(g, wr, a, d, 1'b0, w0, s0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, the number of cycles the strobe (notOutputEnable or notWriteEnable) is held low; legal range 1..15.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-003 notReset  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  master idle; request accepted when req_valid && req_ready at a clk edge.
REQ-006 req_write  in  1  1=write, 0=read.
REQ-007 req_addr  in  12  target address.
REQ-008 req_wdata  in  8  write data.
REQ-009 rsp_valid  out  1  one-cycle completion pulse, for both reads and writes.
REQ-010 rsp_rdata  out  8  last captured read byte.
REQ-011 address  out  12  memory address bus.
REQ-012 notChipEnable  out  1  active-low chip select.
REQ-013 notOutputEnable  out  1  active-low read strobe.
REQ-014 notWriteEnable  out  1  active-low write strobe.
REQ-015 io  inout  8  bidirectional data bus; released (Z) unless the master is writing.

Function
REQ-016 SHALL implement the states IDLE, SETUP, ACCESS and HOLD, with every bus output registered (glitch-free).
REQ-017 IDLE: req_ready=1, all strobes high, io=Z; on acceptance, latch addr/write/wdata and go to SETUP.
REQ-018 SETUP (1 cycle): address=latched addr, notChipEnable=0, OE/WE high; on a write, io=wdata; go to ACCESS and load the counter with ACCESS_CYCLES-1.
REQ-019 ACCESS (ACCESS_CYCLES cycles): on a read, notOutputEnable=0; on a write, notWriteEnable=0 and io=wdata; the counter decrements each cycle; at counter==0 go to HOLD.
REQ-020 On a read, the master SHALL capture io into rsp_rdata at the clk edge that leaves ACCESS.
REQ-021 HOLD (1 cycle): OE/WE high, notChipEnable=0, address held, io still driven on a write (hold time); rsp_valid=1; go to IDLE.
REQ-022 req_ready SHALL be 0 in SETUP, ACCESS and HOLD; requests in those states are not accepted.
REQ-023 Transaction length SHALL be ACCESS_CYCLES+2 cycles from SETUP to HOLD inclusive; back-to-back period is ACCESS_CYCLES+3.
REQ-024 notOutputEnable and notWriteEnable SHALL never be low in the same cycle.
REQ-025 io SHALL never be driven in a cycle where notOutputEnable=0.
REQ-026 rsp_rdata SHALL hold its value until the next read capture; writes SHALL leave it unchanged.
REQ-027 address SHALL hold its last value in IDLE.

Reset
REQ-028 While notReset=0, outputs SHALL be asynchronously: state=IDLE, notChipEnable=notOutputEnable=notWriteEnable=1, io=Z, address=0, rsp_valid=0, rsp_rdata=0, req_ready=0.
REQ-029 req_ready SHALL become 1 on the first clk edge after notReset deasserts.
REQ-030 Reset mid-transaction SHALL abort it without a rsp_valid pulse and release strobes and io immediately.

Structure
REQ-031 Package mem_bus_pkg SHALL hold the state enum, ADDR_W=12, DATA_W=8 and the default ACCESS_CYCLES.
REQ-032 The block SHALL be a single module with no sub-module; it SHALL use a 4-bit down-counter.

Verification
REQ-033 Reset: hold notReset=0 -> strobes=1, io=Z, address=0, rsp_rdata=0, rsp_valid=0; release -> req_ready=1 one edge later.
REQ-034 Read: 0x005 against a ROM model returning 0xA3, ACCESS_CYCLES=2 -> CE low 4 cycles, OE low exactly 2, WE never low, rsp_valid in the 4th cycle after acceptance, rsp_rdata=0xA3.
REQ-035 Write: 0x7FF, data 0x5C -> WE low 2 cycles, io=0x5C from SETUP through HOLD, OE never low, rsp_rdata unchanged.
REQ-036 Back-to-back: req_valid held high with reads 0x010 then 0x011 -> second accepted in the IDLE cycle, SETUP starts 5 cycles apart.
REQ-037 Reset during ACCESS of a write -> strobes high and io=Z with no clk edge, no rsp_valid; a following read of 0x020 completes normally.
REQ-038 ACCESS_CYCLES=1, read 0x003 returning 0x3C -> OE low 1 cycle, rsp_valid 3 cycles after acceptance, rsp_rdata=0x3C.
